oam_dma: RTL and testbench

- Sprite DMA controller and bus arbiter between the 6502 core and the shared system bus.
- A CPU write to $4014 halts the CPU via `cpu_rdy`.
- The block then takes the bus and copies 256 bytes from page {PP,00}..{PP,FF} to the OAM data port $2004.
- It then returns bus ownership to the CPU.

---
 rtl/dma_pkg.sv | 23 ++
 rtl/oam_dma.sv | 129 ++++++++++++
 tb/tb_oam_dma.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the sprite DMA controller (oam_dma).
//   dma_state_t        : controller state encoding
//   DEF_DMA_REG_ADDR   : default CPU write address that starts a transfer
//   DEF_OAM_DATA_ADDR  : default destination address of every DMA write
//   DEF_XFER_LEN       : default bytes per transfer (power of two, <= 256)
// -----------------------------------------------------------------------------
package dma_pkg;

  localparam logic [15:0] DEF_DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] DEF_OAM_DATA_ADDR = 16'h2004;
  localparam int          DEF_XFER_LEN      = 256;

  typedef enum logic [2:0] {
    IDLE,   // CPU owns the bus
    HALT,   // first stolen cycle, dummy read
    ALIGN,  // optional extra dummy read so READ lands on an even cycle
    READ,   // fetch source byte (even cycle)
    WRITE   // store byte to OAM data port (odd cycle)
  } dma_state_t;

endpackage : dma_pkg

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
// Sprite DMA controller and bus arbiter between the 6502 core and the shared
// system bus. A CPU write to DMA_REG_ADDR stalls the CPU, copies XFER_LEN
// bytes from page {PP,00} to OAM_DATA_ADDR, then hands the bus back.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   cpu_rw      in   CPU bus direction (1 = read, 0 = write)
//   cpu_addr    in   CPU address [15:0]
//   cpu_wdata   in   CPU write data [7:0]
//   cpu_rdy     out  0 = CPU must stall and hold its request
//   bus_rw      out  arbitrated bus direction
//   bus_addr    out  arbitrated bus address [15:0]
//   bus_wdata   out  arbitrated write data [7:0]
//   bus_rdata   in   read data from the bus [7:0]
//   dma_active  out  1 while the DMA owns the bus
//
// XFER_LEN must be a power of two no larger than 256; the 8-bit index wraps
// inside the source page and never carries into the page byte.
// -----------------------------------------------------------------------------
module oam_dma
  import dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DEF_DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = DEF_OAM_DATA_ADDR,
  parameter int          XFER_LEN      = DEF_XFER_LEN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_rdy,
  output logic        bus_rw,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        dma_active
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t r_state;
  logic       r_parity;  // 0 on even cycles, 1 on odd cycles
  logic [7:0] r_idx;
  logic [7:0] r_page;
  logic [7:0] r_buf;

  logic       w_trigger;

  // The triggering write is still passed through to the bus this cycle.
  assign w_trigger = (r_state == IDLE) && !cpu_rw && (cpu_addr == DMA_REG_ADDR);

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values of one another, as real flops do.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_parity <= 1'b0;
      r_idx    <= 8'h00;
      r_page   <= 8'h00;
      r_buf    <= 8'h00;
    end else begin
      r_parity <= ~r_parity;
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_page  <= cpu_wdata;
            r_idx   <= 8'h00;
            r_state <= HALT;
          end
        end
        HALT: begin
          // Parity in the next cycle is ~r_parity; READ must fall on even
          // cycles, so go straight to READ only when the current cycle is odd.
          r_state <= r_parity ? READ : ALIGN;
        end
        ALIGN: begin
          r_state <= READ;
        end
        READ: begin
          r_buf   <= bus_rdata;
          r_state <= WRITE;
        end
        WRITE: begin
          if (r_idx == LAST_IDX) begin
            r_idx   <= 8'h00;
            r_state <= IDLE;
          end else begin
            r_idx   <= r_idx + 8'h01;
            r_state <= READ;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Bus mux: passthrough in IDLE, DMA-driven otherwise.
  // NOTE: each output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cpu_rdy    = (r_state == IDLE);
    dma_active = (r_state != IDLE);
    bus_rw     = 1'b1;
    bus_addr   = {r_page, 8'h00};  // dummy-read address for HALT/ALIGN
    bus_wdata  = r_buf;            // ignored by slaves while bus_rw = 1
    case (r_state)
      IDLE: begin
        bus_rw    = cpu_rw;
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
      end
      READ: begin
        bus_addr = {r_page, r_idx};
      end
      WRITE: begin
        bus_rw   = 1'b0;
        bus_addr = OAM_DATA_ADDR;
      end
      default: ;
    endcase
  end

endmodule : oam_dma

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma
// Self-checking bench for oam_dma: table-driven IDLE passthrough vectors, a
// scoreboard of expected OAM bytes filled at each trigger and drained by a
// bus monitor, and hand-written sequences for alignment, abort and
// reset-versus-trigger corner cases.
// -----------------------------------------------------------------------------
module tb_oam_dma;

  localparam logic [15:0] DMA_REG = 16'h4014;
  localparam logic [15:0] OAM_REG = 16'h2004;
  localparam int          XFER    = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rdy;
  logic        bus_rw;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        dma_active;

  oam_dma dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_rw     (cpu_rw),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdy    (cpu_rdy),
    .bus_rw     (bus_rw),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  // Bus memory model.
  logic [7:0] mem [0:65535];
  always_comb bus_rdata = mem[bus_addr];

  // Reference cycle parity: 0 on the first cycle after reset, toggles each edge.
  logic tb_par;
  always @(posedge clk) begin
    if (reset) tb_par <= 1'b0;
    else       tb_par <= ~tb_par;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and monitor state.
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_page = 8'h00;
  int          mon_idx  = 0;
  int          n_writes = 0;
  logic [15:0] last_read_addr = 16'h0000;
  logic        prev_rw  = 1'b1;
  logic [15:0] prev_addr = 16'h0000;
  logic        prev_par = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && dma_active) begin
        check("src_page_bound",
              32'((bus_rw && bus_addr[15:8] == mon_page) || (!bus_rw && bus_addr == OAM_REG)),
              32'd1);
        if (!bus_rw) begin
          n_writes++;
          check("wr_addr",   bus_addr, OAM_REG);
          check("wr_parity", tb_par, 1'b1);
          check("rd_before_wr", prev_rw, 1'b1);
          check("rd_addr",   prev_addr, {mon_page, 8'(mon_idx)});
          check("rd_parity", prev_par, 1'b0);
          if (exp_q.size() == 0) check("oam_write_unexpected", 32'd1, 32'd0);
          else                   check("oam_data", bus_wdata, exp_q.pop_front());
          last_read_addr = prev_addr;
          mon_idx++;
        end
      end
      prev_rw   = bus_rw;
      prev_addr = bus_addr;
      prev_par  = tb_par;
    end
  end

  // Called at posedge+#1. want_par: 0/1 forces the trigger-cycle parity, 2 = any.
  task automatic start_dma(input logic [7:0] pg, input int want_par, output int exp_len);
    if (want_par != 2 && tb_par != 1'(want_par)) begin
      @(posedge clk); #1;
    end
    // HALT follows the trigger cycle; READ is next only if HALT is odd,
    // i.e. the trigger cycle is even.
    exp_len  = (tb_par == 1'b0) ? 1 + 2 * XFER : 2 + 2 * XFER;
    mon_page = pg;
    mon_idx  = 0;
    for (int i = 0; i < XFER; i++) exp_q.push_back(mem[{pg, 8'(i)}]);
    cpu_rw    = 1'b0;
    cpu_addr  = DMA_REG;
    cpu_wdata = pg;
    @(negedge clk); #1;
    check("trig_pass_rw",    bus_rw, 1'b0);
    check("trig_pass_addr",  bus_addr, DMA_REG);
    check("trig_pass_wdata", bus_wdata, pg);
    check("trig_rdy",        cpu_rdy, 1'b1);
    @(posedge clk); #1;
    cpu_rw    = 1'b1;
    cpu_addr  = 16'h8000;
    cpu_wdata = 8'h00;
  endtask

  // Called at posedge+#1 right after start_dma.
  task automatic finish_dma(input logic [7:0] pg, input int exp_len);
    int  low_cnt;
    bit  done;
    low_cnt = 0;
    done    = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk); #1;
      if (!cpu_rdy) low_cnt++;
      else          done = 1'b1;
    end
    check("rdy_low_cycles", low_cnt, exp_len);
    check("queue_drained",  exp_q.size(), 0);
    check("last_read_addr", last_read_addr, {pg, 8'hFF});
    check("post_active",    dma_active, 1'b0);
    check("post_pass_addr", bus_addr, 16'h8000);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        exp_rdy;
    logic        exp_active;
  } vec_t;

  vec_t vecs [6];

  initial begin : stim
    int len;
    bit found;
    int w0;

    for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'hA5;
    for (int i = 0; i < 256; i++) begin
      mem[{8'h03, 8'(i)}] = 8'(i * 3 + 1);
      mem[{8'h07, 8'(i)}] = 8'(i) ^ 8'h3C;
      mem[{8'h08, 8'(i)}] = 8'hEE;
    end

    vecs[0] = '{1'b1, 16'h8000, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{1'b1, DMA_REG,  8'h00, 1'b1, 1'b0};  // read of trigger reg
    vecs[2] = '{1'b0, 16'h4015, 8'h02, 1'b1, 1'b0};  // neighbour address
    vecs[3] = '{1'b0, 16'h4013, 8'h07, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 16'h0123, 8'h5A, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 16'hFFFC, 8'hC3, 1'b1, 1'b0};

    // Reset state.
    reset = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus_addr", bus_addr, 16'h8000);
    check("rst_bus_rw",   bus_rw, 1'b1);
    check("rst_cpu_rdy",  cpu_rdy, 1'b1);
    check("rst_active",   dma_active, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // IDLE passthrough vectors; none may start a transfer.
    for (int v = 0; v < 6; v++) begin
      cpu_rw = vecs[v].rw; cpu_addr = vecs[v].addr; cpu_wdata = vecs[v].wdata;
      @(negedge clk);
      check("vec_bus_rw",    bus_rw, vecs[v].rw);
      check("vec_bus_addr",  bus_addr, vecs[v].addr);
      check("vec_bus_wdata", bus_wdata, vecs[v].wdata);
      check("vec_rdy",       cpu_rdy, vecs[v].exp_rdy);
      check("vec_active",    dma_active, vecs[v].exp_active);
      @(posedge clk); #1;
      check("vec_no_start",  dma_active, 1'b0);
    end

    // Trigger on an odd cycle: HALT lands even, ALIGN inserted, 514 cycles.
    start_dma(8'h02, 1, len);
    check("page2_len_514", len, 514);
    check("page2_first_byte", mem[16'h0200], 8'hA5);
    finish_dma(8'h02, len);

    // Trigger on an even cycle: no ALIGN, 513 cycles, stays within page 7.
    start_dma(8'h07, 0, len);
    check("page7_len_513", len, 513);
    finish_dma(8'h07, len);

    // Write of 0 to the trigger reg transfers page 0.
    start_dma(8'h00, 2, len);
    finish_dma(8'h00, len);

    // Abort during the WRITE of idx 8'h40.
    start_dma(8'h05, 2, len);
    found = 1'b0;
    for (int c = 0; c < 600 && !found; c++) begin
      @(negedge clk); #1;
      if (mon_idx == 'h41 && bus_rw == 1'b0) found = 1'b1;
    end
    check("abort_reached_idx40", found, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    w0 = n_writes;
    @(negedge clk); #1;
    check("abort_rdy",       cpu_rdy, 1'b1);
    check("abort_active",    dma_active, 1'b0);
    check("abort_pass_addr", bus_addr, 16'h8000);
    check("abort_pass_rw",   bus_rw, 1'b1);
    repeat (20) @(negedge clk);
    check("abort_no_writes", n_writes - w0, 0);
    @(posedge clk); #1;
    start_dma(8'h03, 2, len);
    finish_dma(8'h03, len);

    // Trigger and reset at the same edge: reset wins.
    reset = 1'b1; cpu_rw = 1'b0; cpu_addr = DMA_REG; cpu_wdata = 8'h09;
    @(posedge clk); #1;
    reset = 1'b0; cpu_rw = 1'b1; cpu_addr = 16'h8000;
    @(negedge clk);
    check("rst_wins_active", dma_active, 1'b0);
    check("rst_wins_rdy",    cpu_rdy, 1'b1);
    @(posedge clk); #1;
    check("rst_wins_idle",   dma_active, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule : tb_oam_dma
